// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit load/store front end for a 16-bit asynchronous SRAM
module sram_ctrl #(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    // Last value of cnt in each half-word phase.
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        op_read;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [31:0] offset;
    logic        unused_offset_bits;

    // Byte offset into the SRAM window; wraps modulo 2^32 below BASE_ADDR.
    assign offset = address - BASE_ADDR;

    // Byte-lane bits and the part of the offset above the 17-bit word are dropped.
    assign unused_offset_bits = &{offset[31:19], offset[1:0]};

    // Pipeline may advance when nothing is pending or the access is finishing.
    assign ready = ((state == IDLE) && !mem_read && !mem_write) || (state == DONE);

    // Access sequencer: low half-word phase, high half-word phase, one-cycle DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_read     <= 1'b0;
            word        <= '0;
            wdata       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                    if (mem_read || mem_write) begin
                        // Reads win when both requests are raised together.
                        op_read    <= mem_read;
                        word       <= offset[18:2];
                        wdata      <= write_data;
                        cnt        <= '0;
                        state      <= LOW;
                        sram_addr  <= {offset[18:2], 1'b0};
                        sram_dq_oe <= !mem_read;
                        sram_we_n  <= mem_read;
                        if (!mem_read) begin
                            sram_dq_out <= write_data[15:0];
                        end
                    end
                end
                LOW: begin
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= HIGH;
                        sram_addr <= {word, 1'b1};
                        if (op_read) begin
                            read_data[15:0] <= sram_dq_in;
                        end else begin
                            sram_dq_out <= wdata[31:16];
                        end
                    end else begin
                        cnt       <= cnt + 4'd1;
                        sram_addr <= {word, 1'b0};
                        if (!op_read) begin
                            sram_dq_out <= wdata[15:0];
                        end
                    end
                end
                HIGH: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        state      <= DONE;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (op_read) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                    end else begin
                        cnt       <= cnt + 4'd1;
                        sram_addr <= {word, 1'b1};
                        if (!op_read) begin
                            sram_dq_out <= wdata[31:16];
                        end
                    end
                end
                DONE: begin
                    // Requests are ignored here; a held request restarts from IDLE.
                    state      <= IDLE;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl with a word-level reference memory
module tb_sram_ctrl;

    localparam int          WAITC = 3;
    localparam logic [31:0] BASE  = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int checks   = 0;
    int failures = 0;

    // Word-level reference memory and the expected read_data register.
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd;

    // Half-word SRAM device model.
    logic [15:0] sram [0:262143] = '{default: 16'h0000};

    sram_ctrl #(
        .WAIT_CYCLES(WAITC),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM device: asynchronous read, write on clock edges while strobed.
    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            sram[sram_addr] <= sram_dq_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_lookup(input int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return 32'h0;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] diff;
        diff = addr - BASE;
        return int'((diff / 32'd4) % 32'd131072);
    endfunction

    // One complete access; called just after a rising edge with the DUT in IDLE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic drop, input string tag);
        int          w;
        int          low;
        int          cyc;
        int          oe_bad;
        bit          done;
        logic        is_rd;
        logic [31:0] exp_val;
        logic [31:0] rd_at_done;
        logic [17:0] aq[$];
        logic [15:0] dq[$];
        logic        wq[$];
        w       = word_of(addr);
        is_rd   = rd;
        exp_val = is_rd ? ref_lookup(w) : exp_rd;
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = wd;
        low = 0; cyc = 0; oe_bad = 0; done = 0; rd_at_done = 'x;
        while (!done && cyc < 50) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
                rd_at_done = read_data;
            end else begin
                low++;
                if (cyc > 0) begin
                    aq.push_back(sram_addr);
                    dq.push_back(sram_dq_out);
                    wq.push_back(sram_we_n);
                    if (sram_dq_oe !== !sram_we_n) oe_bad++;
                end
            end
            cyc++;
            if (!done) begin
                @(posedge clk); #1;
                if (cyc == 1 && drop) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                    address   = $urandom;
                end
            end
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " ready_low"}, low, 2 * WAITC + 1);
        chk({tag, " phase_cycles"}, aq.size(), 2 * WAITC);
        for (int k = 0; k < aq.size() && k < 2 * WAITC; k++) begin
            chk($sformatf("%s addr[%0d]", tag, k), 32'(aq[k]),
                32'((w * 2) + ((k >= WAITC) ? 1 : 0)));
            chk($sformatf("%s we_n[%0d]", tag, k), 32'(wq[k]), 32'(is_rd));
            if (!is_rd) begin
                chk($sformatf("%s dq_out[%0d]", tag, k), 32'(dq[k]),
                    (k < WAITC) ? 32'(wd[15:0]) : 32'(wd[31:16]));
            end
        end
        chk({tag, " oe_vs_we"}, oe_bad, 0);
        chk({tag, " read_data"}, rd_at_done, exp_val);
        if (is_rd) exp_rd = exp_val;
        else       ref_mem[w] = wd;
        @(posedge clk); #1;
        if (drop) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        int          w;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
        exp_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst read_data", read_data, 32'h0);
        chk("rst sram_addr", 32'(sram_addr), 32'h0);
        chk("rst dq_out", 32'(sram_dq_out), 32'h0);
        chk("rst oe", 32'(sram_dq_oe), 32'h0);
        chk("rst we_n", 32'(sram_we_n), 32'h1);
        chk("rst ready", 32'(ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b1, "wr_deadbeef");
        access(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b1, "wr_1028");
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, "rd_1028");
        chk("sram half 2", 32'(sram[2]), 32'h5678);
        chk("sram half 3", 32'(sram[3]), 32'h1234);
        access(1'b1, 1'b1, 32'd1024, 32'h0BADF00D, 1'b1, "rd_wr_both");

        // Reset during the second low-phase cycle of a write.
        mem_write = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
        @(negedge clk);
        @(posedge clk); #1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort we_n", 32'(sram_we_n), 32'h1);
        chk("abort oe", 32'(sram_dq_oe), 32'h0);
        chk("abort ready", 32'(ready), 32'h1);
        chk("abort read_data", read_data, 32'h0);
        exp_rd = '0;
        w = word_of(32'd1032);
        ref_mem[w] = {ref_lookup(w) >> 16, 16'hF00D} ;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort idle we_n %0d", i), 32'(sram_we_n), 32'h1);
        end
        @(posedge clk); #1;

        access(1'b0, 1'b1, 32'd1024 + 32'h80000, 32'hA5A55A5A, 1'b1, "wrap_wr");
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, "wrap_rd");

        access(1'b0, 1'b1, 32'd1036, 32'h13579BDF, 1'b0, "b2b_wr");
        access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b1, "b2b_rd");

        for (int i = 0; i < 24; i++) begin
            a  = BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + 32'h80000;
            d  = $urandom;
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, a, d, (i == 23) ? 1'b1 : 1'($urandom_range(0, 1)),
                   $sformatf("rand%0d", i));
        end
        mem_read = 1'b0; mem_write = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 3: cycles each 16-bit half-word access is held on the SRAM bus; legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 1024: byte address that maps to SRAM word 0.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  single rising-edge clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mem_read  in  1  load request from the control path.
REQ-007 mem_write  in  1  store request from the control path.
REQ-008 address  in  32  byte address of the request.
REQ-009 write_data  in  32  store data.
REQ-010 read_data  out  32  load result, registered.
REQ-011 ready  out  1  high = no access pending; low = pipeline must freeze.
REQ-012 sram_addr  out  18  SRAM half-word address, registered.
REQ-013 sram_dq_out  out  16  data driven to the SRAM, registered.
REQ-014 sram_dq_oe  out  1  high = controller drives the data bus, registered.
REQ-015 sram_dq_in  in  16  data returned by the SRAM.
REQ-016 sram_we_n  out  1  active-low SRAM write strobe, registered.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOW, HIGH and DONE, plus a 4-bit cycle counter cnt.
REQ-018 IDLE: if mem_read or mem_write is high, the FSM SHALL latch op, word, and write_data, clear cnt, and go to LOW.
- op = read when mem_read=1, else write; mem_read has priority when both are high.
- word = ((address - BASE_ADDR) mod 2^32) >> 2, truncated to 17 bits.
REQ-019 The low 2 address bits SHALL be ignored; word SHALL wrap modulo 2^17.
REQ-020 LOW: every cycle the FSM SHALL drive sram_addr = {word, 1'b0}.
- Write: sram_dq_out = wdata[15:0], sram_dq_oe = 1, sram_we_n = 0.
- Read: sram_dq_oe = 0, sram_we_n = 1.
REQ-021 LOW: cnt SHALL increment each cycle.
- When cnt = WAIT_CYCLES-1 on a read, sram_dq_in SHALL be captured into read_data[15:0].
- When cnt = WAIT_CYCLES-1, the FSM SHALL clear cnt and go to HIGH.
REQ-022 HIGH: behaves as LOW, with these differences:
- sram_addr = {word, 1'b1}.
- Write data = wdata[31:16]; a read captures into read_data[31:16].
- On cnt = WAIT_CYCLES-1 the FSM SHALL go to DONE.
REQ-023 DONE SHALL last exactly one cycle.
- sram_we_n = 1 and sram_dq_oe = 0.
- The next state SHALL be IDLE; no new request is accepted in DONE.
REQ-024 ready SHALL be combinational: ready = (state=IDLE and not mem_read and not mem_write) or state=DONE.
REQ-025 Latency: from a request seen in IDLE, ready SHALL stay low for exactly 2*WAIT_CYCLES+1 cycles, then be high for one cycle in DONE.
REQ-026 Once accepted, the access SHALL complete even if mem_read or mem_write drops or address changes mid-access.
REQ-027 A request still high in the IDLE cycle after DONE SHALL start a new access (back-to-back operation).
REQ-028 read_data SHALL change only on read captures; write accesses SHALL leave it unchanged.
REQ-029 The bits of read_data not yet captured SHALL hold their previous values during a read.
REQ-030 In IDLE and DONE: sram_we_n = 1 and sram_dq_oe = 0; sram_addr and sram_dq_out hold their last values.

Reset
REQ-031 While rst = 1 at a clock edge, the following SHALL be loaded regardless of state:
- state = IDLE, cnt = 0, read_data = 0;
- sram_addr = 0, sram_dq_out = 0;
- sram_dq_oe = 0, sram_we_n = 1.
REQ-032 Reset mid-access SHALL abort the access; sram_we_n SHALL be 1 from the first post-reset cycle, and no partial write SHALL be retried.

Verification (WAIT_CYCLES = 3, BASE_ADDR = 1024)
REQ-033 Write 0xDEADBEEF at 1024: expect the following, with ready low 7 cycles then high 1 cycle:
- sram_addr = 0, dq_out = 0xBEEF, we_n = 0 for 3 cycles;
- then sram_addr = 1, dq_out = 0xDEAD, we_n = 0 for 3 cycles.
REQ-034 Read at 1028 with the SRAM model holding addr 2 = 0x5678 and addr 3 = 0x1234: expect read_data = 0x12345678 in the DONE cycle, we_n = 1 throughout, ready low 7 cycles.
REQ-035 mem_read = mem_write = 1 at 1024: expect a read access, we_n never 0, read_data updated.
REQ-036 rst asserted in the 2nd LOW cycle of a write: expect we_n = 1, oe = 0, state IDLE, and ready = 1 (with no request) on the next cycle.
REQ-037 Address 1024 + 0x80000: expect word to wrap to 0 and the first half to use sram_addr = 0.
REQ-038 Back-to-back write then read held high: expect DONE, one IDLE cycle, then a new LOW phase, with ready low again for 7 cycles.
